// File: rtl/rf_scoreboard.sv
// Register file with byte-enabled writeback and a per-register busy scoreboard.
// Reads, write forwarding and hazard stall are combinational; busy state and count are registered.
module rf_scoreboard #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned AW    = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [XLEN-1:0]   wd,
  input  logic [XLEN/8-1:0] wbe,
  input  logic [AW-1:0]     ra1,
  input  logic [AW-1:0]     ra2,
  output logic [XLEN-1:0]   rd1,
  output logic [XLEN-1:0]   rd2,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  output logic              stall,
  output logic [AW:0]       busy_cnt
);

  localparam int unsigned NB  = XLEN / 8;
  localparam int unsigned CW  = AW + 1;
  localparam logic        BYP = (BYPASS != 0);

  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] r_busy;
  logic [AW:0]     r_busy_cnt;

  logic            w_wr_en;
  logic [XLEN-1:0] w_wr_merged;
  logic [XLEN-1:0] w_rd1;
  logic [XLEN-1:0] w_rd2;
  logic [NREG-1:0] w_eff_busy;
  logic            w_stall;
  logic            w_accept;
  logic [NREG-1:0] w_busy_nxt;
  logic [AW:0]     w_cnt_nxt;

  assign w_wr_en = we && (wa != '0);

  // Stored word of the target register with the enabled writeback bytes overlaid
  always_comb begin
    w_wr_merged = r_regs[wa];
    for (int unsigned k = 0; k < NB; k++) begin
      if (wbe[k]) w_wr_merged[8*k +: 8] = wd[8*k +: 8];
    end
  end

  always_comb begin
    w_rd1 = r_regs[ra1];
    w_rd2 = r_regs[ra2];
    if (BYP && w_wr_en && (wa == ra1)) w_rd1 = w_wr_merged;
    if (BYP && w_wr_en && (wa == ra2)) w_rd2 = w_wr_merged;
    if (rst || (ra1 == '0)) w_rd1 = '0;
    if (rst || (ra2 == '0)) w_rd2 = '0;
  end

  // A same-cycle writeback releases its register for hazard purposes when forwarding is on
  always_comb begin
    w_eff_busy = r_busy;
    if (BYP && we) w_eff_busy[wa] = 1'b0;
  end

  assign w_stall  = !rst && iss_valid &&
                    (w_eff_busy[ra1] || w_eff_busy[ra2] || w_eff_busy[iss_rd]);
  assign w_accept = iss_valid && !w_stall;

  // Clear on writeback first so an accepted issue to the same register wins
  always_comb begin
    w_busy_nxt = r_busy;
    if (we) w_busy_nxt[wa] = 1'b0;
    if (w_accept) w_busy_nxt[iss_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_comb begin
    w_cnt_nxt = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      w_cnt_nxt = w_cnt_nxt + CW'(w_busy_nxt[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[wa] <= w_wr_merged;
    end
  end

  assign rd1      = w_rd1;
  assign rd2      = w_rd2;
  assign stall    = w_stall;
  assign busy_cnt = r_busy_cnt;

endmodule

// File: doc/rf_scoreboard.md
RF_SCOREBOARD -- requirements
Module: rf_scoreboard

Interface
REQ-001 The block SHALL have parameter XLEN, default 32: register width in bits, multiple of 8, range 8..64.
REQ-002 The block SHALL have parameter NREG, default 32: register count, power of two, range 4..64; AW = log2(NREG).
REQ-003 The block SHALL have parameter BYPASS, default 1: 1 = write-to-read and writeback-to-busy forwarding enabled; 0 = disabled.
REQ-004 The block SHALL have port clk, input, 1: clock, all state updates on rising edge.
REQ-005 The block SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 The block SHALL have port we, input, 1: writeback enable.
REQ-007 The block SHALL have port wa, input, AW: writeback register address.
REQ-008 The block SHALL have port wd, input, XLEN: writeback data.
REQ-009 The block SHALL have port wbe, input, XLEN/8: writeback byte enables, bit k covers wd[8k+7:8k].
REQ-010 The block SHALL have ports ra1 and ra2, input, AW each: read addresses.
REQ-011 The block SHALL have ports rd1 and rd2, output, XLEN each: read data.
REQ-012 The block SHALL have port iss_valid, input, 1: issue request, marks iss_rd pending.
REQ-013 The block SHALL have port iss_rd, input, AW: destination register of the issuing instruction.
REQ-014 The block SHALL have port stall, output, 1: issue blocked by a hazard.
REQ-015 The block SHALL have port busy_cnt, output, AW+1: number of pending registers.

Function
REQ-016 Register 0 SHALL always read 0, SHALL ignore writes and SHALL never be busy.
REQ-017 A write SHALL occur at the clk edge when we=1 and wa!=0; byte k of reg[wa] updates only where wbe[k]=1; other bytes are retained.
REQ-018 Reads SHALL be combinational: rd1 = reg[ra1], rd2 = reg[ra2], giving 0-cycle latency.
REQ-019 When BYPASS=1, we=1 and wa==raN!=0, rdN SHALL return the merged value: wd bytes where wbe=1, stored bytes elsewhere.
REQ-020 When BYPASS=0, rdN SHALL return the stored value only; a write becomes visible on the cycle after its edge.
REQ-021 Per-register busy bits SHALL exist; busy[0] SHALL be constant 0.
REQ-022 effbusy(r) SHALL be busy[r] AND NOT (BYPASS=1 AND we=1 AND wa==r).
REQ-023 stall SHALL be iss_valid AND (effbusy(ra1) OR effbusy(ra2) OR effbusy(iss_rd)), evaluated combinationally.
REQ-024 An issue SHALL be accepted when iss_valid=1 and stall=0; busy[iss_rd] is then set at the edge, unless iss_rd=0.
REQ-025 Writeback SHALL clear busy[wa] at the edge when we=1, regardless of wbe, including when wbe=0.
REQ-026 When an accepted issue and a writeback target the same register in the same cycle, set SHALL win: the register is busy afterwards and the data is written.
REQ-027 A write to a non-busy register SHALL be legal: data is written and busy stays 0.
REQ-028 busy_cnt SHALL be a registered popcount of the busy bits, updated in the same edge as the busy bits, range 0..NREG-1.
REQ-029 stall SHALL have no effect on writes; a rejected issue SHALL change no state.

Reset
REQ-030 While rst=1, all registers, all busy bits and busy_cnt SHALL be 0, with effect immediate and independent of clk.
REQ-031 During reset, rd1=rd2=0 and stall=0 SHALL hold for any inputs; writes and issues are ignored.
REQ-032 Reset asserted mid-operation SHALL discard all pending state; the first edge after deassertion SHALL behave as from power-up.

Verification
REQ-033 The bench SHALL cover this scenario: reset, we=1 wa=5 wd=0xDEADBEEF wbe=0xF, then wbe=0x2 wd=0x00001200 -> reg5=0xDEAD12EF; ra1=5 in the write cycle gives 0xDEAD12EF with BYPASS=1 and 0xDEADBEEF with BYPASS=0.
REQ-034 The bench SHALL cover this scenario: we=1 wa=0 wd=0xFFFFFFFF; iss_valid=1 iss_rd=0 -> rd1(ra1=0)=0, busy_cnt=0, stall=0.
REQ-035 The bench SHALL cover this scenario: issue iss_rd=7, next cycle iss_valid=1 ra1=7 -> stall=1; with we=1 wa=7 in that cycle -> stall=0 (BYPASS=1) or stall=1 (BYPASS=0).
REQ-036 The bench SHALL cover this scenario: busy[3]=1, same cycle we=1 wa=3 and accepted issue iss_rd=3 -> reg3 written, busy[3]=1, busy_cnt unchanged.
REQ-037 The bench SHALL cover this scenario: issue regs 1..31 back-to-back, ra1=ra2=0 -> busy_cnt reaches 31; writeback all -> busy_cnt returns to 0.
REQ-038 The bench SHALL cover this scenario: busy_cnt=4 and regs nonzero, rst pulsed between edges -> all outputs 0 immediately; post-reset issue iss_rd=2 -> busy_cnt=1.
